// File: rtl/dbiu_rr_arbiter.sv
// dbiu_rr_arbiter: round-robin merge of per-CPU data-bus ports
// onto one downstream port, one transaction in flight, with watchdog.
module dbiu_rr_arbiter #(
  parameter int N_CPU     = 4,
  parameter int DBUS_AW   = 32,
  parameter int DBUS_DW   = 32,
  parameter int DBUS_ISEL = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [N_CPU-1:0]             req_m2dbiu,
  input  logic [N_CPU*DBUS_AW-1:0]     adr_m2dbiu_flat,
  input  logic [N_CPU*DBUS_DW-1:0]     dat_m2dbiu_flat,
  input  logic [N_CPU-1:0]             we_m2dbiu,
  input  logic [N_CPU*DBUS_ISEL-1:0]   sel_m2dbiu_flat,
  output logic [N_CPU*DBUS_DW-1:0]     dat_dbiu2m_flat,
  output logic [N_CPU-1:0]             ack_dbiu2m,
  output logic                         req_o,
  output logic [DBUS_AW-1:0]           adr_o,
  output logic [DBUS_DW-1:0]           dat_o,
  output logic                         we_o,
  output logic [DBUS_ISEL-1:0]         sel_o,
  input  logic [DBUS_DW-1:0]           dat_i,
  input  logic                         ack_i,
  output logic [$clog2(N_CPU)-1:0]     grant_id_o,
  output logic                         timeout_o
);

  localparam int GW = $clog2(N_CPU);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(N_CPU - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [GW-1:0]              grant_q, grant_d;
  logic [GW-1:0]              last_q, last_d;
  logic [WW-1:0]              wd_q, wd_d;
  logic                       req_q, req_d;
  logic [DBUS_AW-1:0]         adr_q, adr_d;
  logic [DBUS_DW-1:0]         dat_q, dat_d;
  logic                       we_q, we_d;
  logic [DBUS_ISEL-1:0]       sel_q, sel_d;
  logic [N_CPU*DBUS_DW-1:0]   rdata_q, rdata_d;
  logic [N_CPU-1:0]           ack_q, ack_d;
  logic                       tmo_q, tmo_d;

  logic [GW-1:0]              win;
  logic                       found;

  // Round-robin pick: first requester after the last grant, wrapping.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    for (int k = 1; k <= N_CPU; k++) begin
      if (!found && req_m2dbiu[(int'(last_q) + k) % N_CPU]) begin
        win   = GW'((int'(last_q) + k) % N_CPU);
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic of the transaction FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    req_d   = req_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          last_d  = win;
          adr_d   = adr_m2dbiu_flat[win*DBUS_AW +: DBUS_AW];
          dat_d   = dat_m2dbiu_flat[win*DBUS_DW +: DBUS_DW];
          we_d    = we_m2dbiu[win];
          sel_d   = sel_m2dbiu_flat[win*DBUS_ISEL +: DBUS_ISEL];
          req_d   = 1'b1;
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (ack_i) begin
          rdata_d[grant_q*DBUS_DW +: DBUS_DW] = dat_i;
          req_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          state_d        = RESP;
        end else if (wd_q == WD_MAX) begin
          rdata_d[grant_q*DBUS_DW +: DBUS_DW] = '1;
          req_d          = 1'b0;
          ack_d[grant_q] = 1'b1;
          tmo_d          = 1'b1;
          state_d        = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
      req_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign req_o           = req_q;
  assign adr_o           = adr_q;
  assign dat_o           = dat_q;
  assign we_o            = we_q;
  assign sel_o           = sel_q;
  assign dat_dbiu2m_flat = rdata_q;
  assign ack_dbiu2m      = ack_q;
  assign grant_id_o      = grant_q;
  assign timeout_o       = tmo_q;

endmodule
